shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit for the CPU's SLL/SRL/SRA and SLLV/SRLV/SRAV instructions.
- Selects the shift amount from either the 5-bit instruction sa field (zero-extended) or rs[4:0].
- Shifts a 32-bit operand one bit per clock and signals completion with a start/done handshake.
- Sits beside the ALU. The control unit issues start and stalls the pipeline while busy.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only when ready=1.
- op  input  2  00=SLL, 01=SRL, 10=SRA, 11=treated as SRL.
- var_sel  input  1  0: amount = sa (zero-extended); 1: amount = rs_low.
- sa  input  SHAMT_W  instruction shamt field.
- rs_low  input  SHAMT_W  rs[4:0] for variable shifts.
- operand  input  WIDTH  value to shift (rt).
- result  output  WIDTH  shifted value; registered, held until next completion.
- busy  output  1  high while shifting (RUN).
- done  output  1  one-cycle completion pulse, coincident with new result.
- ready  output  1  high in IDLE or DONE; new start accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; acc, cnt, result=0.
  - busy=0, done=0, ready=1.
  - Takes effect immediately, including mid-operation; the in-flight shift is discarded and no done pulse is issued.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge k:
  - acc<=operand; cnt<=(var_sel ? rs_low : sa); latch op.
  - state<=RUN.
- IDLE or DONE, start=0: go to / stay in IDLE.
- RUN, cnt!=0 (each edge):
  - acc shifts one bit: SLL fills 0 at LSB; SRL fills 0 at MSB; SRA replicates acc[WIDTH-1].
  - cnt<=cnt-1.
- RUN, cnt==0: result<=acc, state<=DONE.
- DONE: done=1, busy=0 for exactly one cycle.
- Latency, amount n:
  - Start sampled at edge k. Shifts occur at edges k+1..k+n. result/done update at edge k+n+1.
  - n=0 gives done one cycle after start with result=operand. n=31 gives 32 cycles.
- Inputs sampled only at the accepting edge; operand/sa/rs_low/op/var_sel changes during RUN have no effect.
- start during RUN: ignored, no queuing.
- start in the DONE cycle: accepted (back-to-back). done still pulses only once for the previous operation.
- Outputs are functions of state only (Moore): busy=(state==RUN); done=(state==DONE); ready=~busy.
- result changes only on completion edges or reset.

Test Plan:
1. Reset: rst_n=0 for 3 cycles, then release -> result=0, busy=0, done=0, ready=1.
2. SLL, var_sel=0, sa=4, operand=0x0000_00F1, start at edge k -> busy for 5 cycles; done at edge k+5; result=0x0000_0F10.
3. SRA with rs_low=31, var_sel=1, operand=0x8000_0000 -> done at edge k+32, result=0xFFFF_FFFF. Repeat with op=SRL -> result=0x0000_0001.
4. Zero shift, sa=0, operand=0x1234_5678 -> done one cycle after start, result=0x1234_5678.
5. Back-to-back and ignored start:
   - start held high through RUN -> no restart; only one done per accepted start.
   - start in the DONE cycle with new operand=0x0000_0001, sa=1, SLL -> second done two cycles later, result=0x0000_0002.
6. Reset mid-shift: rst_n low during RUN at cnt=10 -> immediately IDLE, result=0, no done pulse. A following start executes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: bit-serial SLL/SRL/SRA unit with start/done handshake, one shift per clock
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               var_sel,
  input  logic [SHAMT_W-1:0] sa,
  input  logic [SHAMT_W-1:0] rs_low,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               done,
  output logic               ready
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] acc, shifted;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0] op_r;
  logic accept;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign ready  = ~busy;
  assign accept = ready & start;
  // op 11 falls through to the right-shift path with zero fill, i.e. SRL
  assign shifted = (op_r == 2'b00) ? {acc[WIDTH-2:0], 1'b0}
                                   : {(op_r == 2'b10) ? acc[WIDTH-1] : 1'b0, acc[WIDTH-1:1]};
  always_comb begin
    state_nxt = busy ? ((cnt == '0) ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      op_r   <= '0;
      result <= '0;
    end else if (accept) begin
      acc  <= operand;
      cnt  <= var_sel ? rs_low : sa;
      op_r <= op;
    end else if (busy) begin
      if (cnt != '0) begin
        acc <= shifted;
        cnt <= cnt - 1'b1;
      end else begin
        result <= acc;
      end
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vector table plus hand sequences for back-to-back and mid-shift reset
module tb_shift_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, var_sel;
  logic [1:0]  op;
  logic [4:0]  sa, rs_low;
  logic [31:0] operand, result;
  logic        busy, done, ready;
  int compared = 0, mismatched = 0, done_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic        var_sel;
    logic [4:0]  sa;
    logic [4:0]  rs_low;
    logic [31:0] operand;
    logic [31:0] exp;
    int          n;
  } vec_t;
  vec_t vecs[8];

  shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .var_sel(var_sel),
    .sa(sa), .rs_low(rs_low), .operand(operand),
    .result(result), .busy(busy), .done(done), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, busy_n = 0;
    op = v.op; var_sel = v.var_sel; sa = v.sa; rs_low = v.rs_low; operand = v.operand;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = ~v.op; var_sel = ~v.var_sel; sa = ~v.sa; rs_low = ~v.rs_low; operand = ~v.operand;
    while (!done && cyc < 40) begin
      busy_n += busy ? 1 : 0;
      tick();
      cyc++;
    end
    chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.n + 1));
    chk($sformatf("v%0d busy_cycles", idx), 32'(busy_n), 32'(v.n + 1));
    chk($sformatf("v%0d result", idx), result, v.exp);
    chk($sformatf("v%0d done_ready_busy", idx), {29'd0, done, ready, busy}, 32'b110);
    tick();
    chk($sformatf("v%0d post_done", idx), {29'd0, done, ready, busy}, 32'b010);
    chk($sformatf("v%0d result_held", idx), result, v.exp);
  endtask

  initial begin
    int d0;
    vecs[0] = '{2'b00, 1'b0, 5'd4,  5'd0,  32'h0000_00F1, 32'h0000_0F10, 4};
    vecs[1] = '{2'b10, 1'b1, 5'd0,  5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 31};
    vecs[2] = '{2'b01, 1'b1, 5'd0,  5'd31, 32'h8000_0000, 32'h0000_0001, 31};
    vecs[3] = '{2'b00, 1'b0, 5'd0,  5'd7,  32'h1234_5678, 32'h1234_5678, 0};
    vecs[4] = '{2'b11, 1'b0, 5'd8,  5'd0,  32'hF000_0000, 32'h00F0_0000, 8};
    vecs[5] = '{2'b10, 1'b0, 5'd4,  5'd1,  32'h8765_4321, 32'hF876_5432, 4};
    vecs[6] = '{2'b00, 1'b1, 5'd3,  5'd16, 32'h0000_ABCD, 32'hABCD_0000, 16};
    vecs[7] = '{2'b10, 1'b0, 5'd28, 5'd0,  32'h7000_0000, 32'h0000_0007, 28};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; var_sel = 1'b0; sa = '0; rs_low = '0; operand = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset result", result, 32'h0);
    chk("reset done_ready_busy", {29'd0, done, ready, busy}, 32'b010);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // start held through RUN, then re-issued in the DONE cycle
    d0 = done_cnt;
    op = 2'b00; var_sel = 1'b0; sa = 5'd2; operand = 32'h0000_0003;
    start = 1'b1;
    tick();
    operand = 32'hDEAD_BEEF; sa = 5'd9;
    tick();
    chk("hold busy1", {31'd0, busy}, 32'd1);
    tick();
    chk("hold busy2", {31'd0, busy}, 32'd1);
    tick();
    chk("hold done", {29'd0, done, ready, busy}, 32'b110);
    chk("hold result", result, 32'h0000_000C);
    operand = 32'h0000_0001; sa = 5'd1; op = 2'b00;
    tick();
    start = 1'b0;
    chk("b2b accepted", {29'd0, done, ready, busy}, 32'b001);
    tick();
    chk("b2b still busy", {31'd0, busy}, 32'd1);
    tick();
    chk("b2b done", {31'd0, done}, 32'd1);
    chk("b2b result", result, 32'h0000_0002);
    tick();
    chk("b2b done_count", 32'(done_cnt - d0), 32'd2);

    // reset while cnt==10
    op = 2'b00; var_sel = 1'b1; rs_low = 5'd20; operand = 32'h0000_FFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mid busy before reset", {31'd0, busy}, 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid reset outputs", {29'd0, done, ready, busy}, 32'b010);
    chk("mid reset result", result, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("mid reset no done", 32'(done_cnt - d0), 32'd0);
    chk("mid reset idle", {29'd0, done, ready, busy}, 32'b010);
    run_vec(vecs[0], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
